// File: rtl/apb_protocol.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : apb_protocol                                               |
// | Description : APB master FSM (IDLE/SETUP/ACCESS) driving one internal    |
// |               zero-wait-state GPIO slave with MODE/DIR/DOUT/DIN regs.     |
// | Ports       : PCLK, PRESETn       - clock, async active-low reset        |
// |               transfer            - keep issuing transfers while high    |
// |               READ_WRITE          - 1 = read, 0 = write                  |
// |               get_w_paddr/_r_paddr- {slave_sel_n, offset[31:0]}          |
// |               get_w_data_in,PSTRB - write data and byte-lane enables     |
// |               i_port / o_port     - GPIO pad inputs / tri-state outputs  |
// |               PSLVERR,send_r_out  - status/data of last completed xfer   |
// | Options     : APB_GPIO_INPUT_SYNC_EN - two-flop synchronizer on i_port   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module apb_protocol (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        transfer,
  input  logic        READ_WRITE,
  input  logic [32:0] get_w_paddr,
  input  logic [32:0] get_r_paddr,
  input  logic [31:0] get_w_data_in,
  input  logic [3:0]  PSTRB,
  input  logic [31:0] i_port,
  output logic        PSLVERR,
  output logic [31:0] send_r_out,
  output wire  [31:0] o_port
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [31:0] C_OFF_DIN = 32'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_psel;
  logic        w_penable;
  logic        w_pready;
  logic        w_latch;
  logic        w_complete;

  logic        r_pwrite;
  logic [32:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;

  logic [31:0] r_mode;
  logic [31:0] r_dir;
  logic [31:0] r_dout;
  logic [31:0] r_din;

  logic [31:0] w_off;
  logic [31:0] w_wmask;
  logic [31:0] w_rdata;
  logic [31:0] w_pad_oe;
  logic        w_err;
  logic        w_wr;

  // ---------------------------------------------------------------- master FSM
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (transfer) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        // Once in SETUP the transfer always proceeds, regardless of transfer.
        w_psel      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_psel      = 1'b1;
        w_penable   = 1'b1;
        w_state_nxt = transfer ? ST_SETUP : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The GPIO slave never inserts wait states.
  assign w_pready   = (r_state == ST_ACCESS);
  assign w_latch    = (w_state_nxt == ST_SETUP);
  assign w_complete = w_psel & w_penable & w_pready;

  // Request is captured on the edge that enters SETUP and held for the transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_latch) begin
      r_pwrite <= ~READ_WRITE;
      r_paddr  <= READ_WRITE ? get_r_paddr : get_w_paddr;
      r_pwdata <= get_w_data_in;
      r_pstrb  <= PSTRB;
    end
  end

  // ---------------------------------------------------------------- slave decode
  assign w_off = r_paddr[31:0];
  // Bit 32 deselects the slave; DIN is read-only; nothing lives above offset 3.
  assign w_err = r_paddr[32] | (w_off > C_OFF_DIN) | (r_pwrite & (w_off == C_OFF_DIN));
  assign w_wr  = w_complete & r_pwrite & ~w_err;

  generate
    for (genvar gl = 0; gl < 4; gl++) begin : g_lane
      assign w_wmask[8*gl +: 8] = {8{r_pstrb[gl]}};
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    if (!w_err) begin
      case (w_off[1:0])
        2'd0:    w_rdata = r_mode;
        2'd1:    w_rdata = r_dir;
        2'd2:    w_rdata = r_dout;
        default: w_rdata = r_din;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_mode <= '0;
      r_dir  <= '0;
      r_dout <= '0;
    end else if (w_wr) begin
      case (w_off[1:0])
        2'd0:    r_mode <= (r_mode & ~w_wmask) | (r_pwdata & w_wmask);
        2'd1:    r_dir  <= (r_dir  & ~w_wmask) | (r_pwdata & w_wmask);
        2'd2:    r_dout <= (r_dout & ~w_wmask) | (r_pwdata & w_wmask);
        default: ;
      endcase
    end
  end

  // Completion status; write completions leave the read-data register alone.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSLVERR    <= 1'b0;
      send_r_out <= '0;
    end else if (w_complete) begin
      PSLVERR <= w_err;
      if (!r_pwrite) send_r_out <= w_rdata;
    end
  end

  // ---------------------------------------------------------------- GPIO input
`ifdef APB_GPIO_INPUT_SYNC_EN
  logic [31:0] r_din_meta;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_din_meta <= '0;
      r_din      <= '0;
    end else begin
      r_din_meta <= i_port;
      r_din      <= r_din_meta;
    end
  end
`else
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_din <= '0;
    else          r_din <= i_port;
  end
`endif

  // ---------------------------------------------------------------- GPIO output
  // Open-drain bits only ever drive low; a '1' in open-drain releases the pad.
  assign w_pad_oe = r_dir & ~(r_mode & r_dout);

  generate
    for (genvar gp = 0; gp < 32; gp++) begin : g_pad
      assign o_port[gp] = w_pad_oe[gp] ? r_dout[gp] : 1'bz;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_protocol.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_apb_protocol                                            |
// | Description : Self-checking bench for apb_protocol. Two instances share   |
// |               all inputs; one pad bus is pulled up, the other pulled     |
// |               down, so a released (Z) pad reads 1 on one and 0 on other. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_apb_protocol;

  logic        PCLK;
  logic        PRESETn;
  logic        transfer;
  logic        READ_WRITE;
  logic [32:0] get_w_paddr;
  logic [32:0] get_r_paddr;
  logic [31:0] get_w_data_in;
  logic [3:0]  PSTRB;
  logic [31:0] i_port;
  wire         PSLVERR;
  wire  [31:0] send_r_out;
  wire  [31:0] o_pu;
  wire         pslverr_pd;
  wire  [31:0] rdata_pd;
  wire  [31:0] o_pd;

  pullup   (o_pu);
  pulldown (o_pd);

  apb_protocol u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .get_w_paddr(get_w_paddr), .get_r_paddr(get_r_paddr), .get_w_data_in(get_w_data_in),
    .PSTRB(PSTRB), .i_port(i_port), .PSLVERR(PSLVERR), .send_r_out(send_r_out), .o_port(o_pu)
  );

  apb_protocol u_dut_pd (
    .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .get_w_paddr(get_w_paddr), .get_r_paddr(get_r_paddr), .get_w_data_in(get_w_data_in),
    .PSTRB(PSTRB), .i_port(i_port), .PSLVERR(pslverr_pd), .send_r_out(rdata_pd), .o_port(o_pd)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mode, m_dir, m_dout, m_rdata;
  logic        m_err;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  // Pad value seen through a pull resistor of value 'pull'.
  function automatic logic [31:0] pad_exp(input logic pull);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      if (!m_dir[i])       r[i] = pull;
      else if (!m_mode[i]) r[i] = m_dout[i];
      else                 r[i] = m_dout[i] ? pull : 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mode = '0; m_dir = '0; m_dout = '0; m_rdata = '0; m_err = 1'b0;
  endtask

  task automatic model_xfer(input logic rw, input logic [32:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
    logic [31:0] off;
    off   = addr[31:0];
    m_err = addr[32] || (off > 32'd3) || (!rw && off == 32'd3);
    if (rw) begin
      if (m_err)           m_rdata = '0;
      else if (off == 0)   m_rdata = m_mode;
      else if (off == 1)   m_rdata = m_dir;
      else if (off == 2)   m_rdata = m_dout;
      else                 m_rdata = i_port;
    end else if (!m_err) begin
      if (off == 0)      m_mode = merge(m_mode, data, strb);
      else if (off == 1) m_dir  = merge(m_dir,  data, strb);
      else               m_dout = merge(m_dout, data, strb);
    end
  endtask

  task automatic drive_inputs(input logic rw, input logic [32:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    READ_WRITE    = rw;
    // The unselected address carries an erroring value so a wrong pick shows up.
    get_r_paddr   = rw ? addr : {1'b1, $urandom};
    get_w_paddr   = rw ? {1'b1, $urandom} : addr;
    get_w_data_in = data;
    PSTRB         = strb;
  endtask

  task automatic scramble();
    READ_WRITE    = 1'($urandom_range(0, 1));
    get_w_paddr   = {1'($urandom_range(0, 1)), $urandom};
    get_r_paddr   = {1'($urandom_range(0, 1)), $urandom};
    get_w_data_in = $urandom;
    PSTRB         = 4'($urandom_range(0, 15));
  endtask

  // One isolated transfer; transfer drops during SETUP and inputs are scrambled
  // after capture. Returns #1 after the completing edge.
  task automatic xfer(input logic rw, input logic [32:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    drive_inputs(rw, addr, data, strb);
    transfer = 1'b1;
    @(posedge PCLK); #1;
    transfer = 1'b0;
    scramble();
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    model_xfer(rw, addr, data, strb);
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; transfer = 1'b1; READ_WRITE = 1'b0;
    get_w_paddr = {1'b0, 32'd1}; get_r_paddr = '0; get_w_data_in = '1; PSTRB = 4'hF; i_port = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    n_checks++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %0b want 0", PSLVERR); end
    n_checks++; if (send_r_out !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", send_r_out); end
    n_checks++; if (o_pu !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_opu: got %h want ffffffff", o_pu); end
    n_checks++; if (o_pd !== 32'h0) begin n_fail++; $display("FAIL reset_opd: got %h want 0", o_pd); end
    transfer = 1'b0;
    PRESETn  = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset_abort();
    xfer(1'b0, {1'b0, 32'd1}, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, {1'b0, 32'd2}, 32'h0000_1234, 4'hF);
    xfer(1'b1, {1'b0, 32'd2}, 32'h0, 4'h0);
    xfer(1'b0, {1'b0, 32'd5}, 32'h0, 4'hF);
    n_checks++; if (PSLVERR !== 1'b1 || send_r_out !== 32'h1234) begin n_fail++;
      $display("FAIL pre_abort: got err=%0b data=%h want err=1 data=00001234", PSLVERR, send_r_out); end
    // Start a write to MODE and pull reset while in ACCESS.
    drive_inputs(1'b0, {1'b0, 32'd0}, 32'hFFFF_FFFF, 4'hF);
    transfer = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #2;
    model_reset();
    n_checks++; if (PSLVERR !== 1'b0 || send_r_out !== 32'h0) begin n_fail++;
      $display("FAIL async_reset: got err=%0b data=%h want 0/0", PSLVERR, send_r_out); end
    n_checks++; if (o_pu !== 32'hFFFF_FFFF || o_pd !== 32'h0) begin n_fail++;
      $display("FAIL async_reset_pads: got pu=%h pd=%h want ffffffff/0", o_pu, o_pd); end
    transfer = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    xfer(1'b1, {1'b0, 32'd0}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'h0 || PSLVERR !== 1'b0) begin n_fail++;
      $display("FAIL abort_mode: got err=%0b data=%h want 0/0", PSLVERR, send_r_out); end
  endtask

  task automatic test_mode_write();
    xfer(1'b0, {1'b0, 32'd0}, 32'h0, 4'hF);
    n_checks++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL mode_wr_err: got %0b want 0", PSLVERR); end
    xfer(1'b1, {1'b0, 32'd0}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'h0) begin n_fail++; $display("FAIL mode_rd: got %h want 0", send_r_out); end
  endtask

  task automatic test_push_pull();
    xfer(1'b0, {1'b0, 32'd1}, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, {1'b0, 32'd2}, 32'd15, 4'hF);
    n_checks++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL pp_err: got %0b want 0", PSLVERR); end
    n_checks++; if (o_pu !== 32'h0000_000F || o_pd !== 32'h0000_000F) begin n_fail++;
      $display("FAIL pp_pads: got pu=%h pd=%h want 0000000f", o_pu, o_pd); end
  endtask

  task automatic test_din_read();
    xfer(1'b0, {1'b0, 32'd1}, 32'h0, 4'hF);
    i_port = 32'd10;
    repeat (3) @(posedge PCLK);
    #1;
    xfer(1'b1, {1'b0, 32'd3}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'd10 || PSLVERR !== 1'b0) begin n_fail++;
      $display("FAIL din_read: got err=%0b data=%h want 0/0000000a", PSLVERR, send_r_out); end
    n_checks++; if (o_pu !== 32'hFFFF_FFFF || o_pd !== 32'h0) begin n_fail++;
      $display("FAIL din_pads_z: got pu=%h pd=%h want ffffffff/0", o_pu, o_pd); end
  endtask

  task automatic test_errors();
    xfer(1'b0, {1'b0, 32'd1}, 32'h0000_00FF, 4'hF);
    xfer(1'b1, {1'b0, 32'd1}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'hFF || PSLVERR !== 1'b0) begin n_fail++;
      $display("FAIL err_setup: got err=%0b data=%h want 0/000000ff", PSLVERR, send_r_out); end
    xfer(1'b0, {1'b0, 32'd3}, 32'hFFFF_FFFF, 4'hF);
    n_checks++; if (PSLVERR !== 1'b1 || send_r_out !== 32'hFF) begin n_fail++;
      $display("FAIL err_wr_din: got err=%0b data=%h want 1/000000ff", PSLVERR, send_r_out); end
    xfer(1'b0, {1'b0, 32'd5}, 32'hFFFF_FFFF, 4'hF);
    n_checks++; if (PSLVERR !== 1'b1) begin n_fail++; $display("FAIL err_wr_off5: got %0b want 1", PSLVERR); end
    xfer(1'b0, {1'b1, 32'd1}, 32'h0, 4'hF);
    n_checks++; if (PSLVERR !== 1'b1) begin n_fail++; $display("FAIL err_wr_nosel: got %0b want 1", PSLVERR); end
    xfer(1'b1, {1'b0, 32'd1}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'hFF || PSLVERR !== 1'b0) begin n_fail++;
      $display("FAIL err_dir_kept: got err=%0b data=%h want 0/000000ff", PSLVERR, send_r_out); end
    xfer(1'b1, {1'b1, 32'd2}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'h0 || PSLVERR !== 1'b1) begin n_fail++;
      $display("FAIL err_rd_nosel: got err=%0b data=%h want 1/0", PSLVERR, send_r_out); end
  endtask

  task automatic test_strobe();
    xfer(1'b0, {1'b0, 32'd2}, 32'h0, 4'hF);
    xfer(1'b0, {1'b0, 32'd2}, 32'hFFFF_FFFF, 4'b0010);
    xfer(1'b1, {1'b0, 32'd2}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'h0000_FF00) begin n_fail++;
      $display("FAIL strb_lane1: got %h want 0000ff00", send_r_out); end
    xfer(1'b0, {1'b0, 32'd2}, 32'h1234_5678, 4'b0000);
    n_checks++; if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL strb_none_err: got %0b want 0", PSLVERR); end
    xfer(1'b1, {1'b0, 32'd2}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'h0000_FF00) begin n_fail++;
      $display("FAIL strb_none_kept: got %h want 0000ff00", send_r_out); end
  endtask

  task automatic test_open_drain();
    xfer(1'b0, {1'b0, 32'd0}, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, {1'b0, 32'd1}, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, {1'b0, 32'd2}, 32'h0000_000F, 4'hF);
    n_checks++; if (o_pu !== 32'h0000_000F || o_pd !== 32'h0) begin n_fail++;
      $display("FAIL od_pads: got pu=%h pd=%h want 0000000f/0", o_pu, o_pd); end
    xfer(1'b0, {1'b0, 32'd0}, 32'h0, 4'hF);
    n_checks++; if (o_pd !== 32'h0000_000F) begin n_fail++;
      $display("FAIL od_to_pp: got pd=%h want 0000000f", o_pd); end
  endtask

  task automatic test_back_to_back();
    drive_inputs(1'b0, {1'b0, 32'd2}, 32'hA5A5_5A5A, 4'hF);
    transfer = 1'b1;
    @(posedge PCLK); #1;
    scramble();
    @(posedge PCLK); #1;
    drive_inputs(1'b1, {1'b0, 32'd2}, 32'h0, 4'h0);
    @(posedge PCLK); #1;
    model_xfer(1'b0, {1'b0, 32'd2}, 32'hA5A5_5A5A, 4'hF);
    n_checks++; if (PSLVERR !== 1'b0 || o_pd !== pad_exp(1'b0)) begin n_fail++;
      $display("FAIL b2b_write: got err=%0b pd=%h want 0/%h", PSLVERR, o_pd, pad_exp(1'b0)); end
    transfer = 1'b0;
    scramble();
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    model_xfer(1'b1, {1'b0, 32'd2}, 32'h0, 4'h0);
    n_checks++; if (send_r_out !== 32'hA5A5_5A5A || PSLVERR !== 1'b0) begin n_fail++;
      $display("FAIL b2b_read: got err=%0b data=%h want 0/a5a55a5a", PSLVERR, send_r_out); end
  endtask

  task automatic test_random();
    logic        rw;
    logic [32:0] addr;
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0, 1:    addr[31:0] = 32'($urandom_range(0, 3));
        2:       addr[31:0] = 32'd4 + 32'($urandom_range(0, 100));
        3:       addr[31:0] = $urandom;
        default: addr[31:0] = 32'($urandom_range(0, 3));
      endcase
      addr[32] = ($urandom_range(0, 9) == 0);
      i_port   = $urandom;
      xfer(rw, addr, $urandom, 4'($urandom_range(0, 15)));
      n_checks++; if (PSLVERR !== m_err) begin n_fail++;
        $display("FAIL rnd_err[%0d]: got %0b want %0b", n, PSLVERR, m_err); end
      n_checks++; if (send_r_out !== m_rdata) begin n_fail++;
        $display("FAIL rnd_rdata[%0d]: got %h want %h", n, send_r_out, m_rdata); end
      n_checks++; if (o_pu !== pad_exp(1'b1)) begin n_fail++;
        $display("FAIL rnd_opu[%0d]: got %h want %h", n, o_pu, pad_exp(1'b1)); end
      n_checks++; if (o_pd !== pad_exp(1'b0)) begin n_fail++;
        $display("FAIL rnd_opd[%0d]: got %h want %h", n, o_pd, pad_exp(1'b0)); end
      n_checks++; if (pslverr_pd !== m_err || rdata_pd !== m_rdata) begin n_fail++;
        $display("FAIL rnd_twin[%0d]: got err=%0b data=%h want %0b/%h", n, pslverr_pd, rdata_pd, m_err, m_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_mode_write();
    test_push_pull();
    test_din_read();
    test_errors();
    test_strobe();
    test_open_drain();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_protocol.md
APB_PROTOCOL -- requirements
Module: apb_protocol

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 PCLK input 1: rising-edge clock for all state.
REQ-003 PRESETn input 1: asynchronous active-low reset.
REQ-004 transfer input 1: request; while high, the internal master issues back-to-back APB transfers.
REQ-005 READ_WRITE input 1: 1 = read, 0 = write.
REQ-006 get_w_paddr input 33: write address; bit 32 = slave select, bits 31:0 = register offset.
REQ-007 get_r_paddr input 33: read address, same format as get_w_paddr.
REQ-008 get_w_data_in input 32: write data.
REQ-009 PSTRB input 4: write byte-lane enables; bit i enables data bits 8i+7:8i.
REQ-010 i_port input 32: GPIO pad inputs.
REQ-011 PSLVERR output 1: slave error of the last completed transfer.
REQ-012 send_r_out output 32: data of the last completed read.
REQ-013 o_port output 32: GPIO pad outputs.

Function
REQ-014 The block SHALL contain an APB master FSM (IDLE, SETUP, ACCESS) and one zero-wait-state GPIO slave.
REQ-015 FSM transitions SHALL be: IDLE->SETUP when transfer=1; SETUP->ACCESS always; ACCESS->SETUP when transfer=1; ACCESS->IDLE when transfer=0.
REQ-016 On entry to SETUP, the master SHALL latch READ_WRITE, the selected address (get_r_paddr if read, else get_w_paddr), get_w_data_in and PSTRB.
REQ-017 PENABLE SHALL be high only in ACCESS; PREADY SHALL be 1 in ACCESS; a transfer SHALL complete at the rising edge ending ACCESS.
REQ-018 The slave SHALL be selected when address bit 32 = 0; bit 32 = 1 SHALL complete with error and no register change.
REQ-019 The register map SHALL be: offset 0 MODE (RW, per bit 0 = push-pull, 1 = open-drain); offset 1 DIR (RW, per bit 1 = output, 0 = input); offset 2 DOUT (RW); offset 3 DIN (RO, sampled i_port).
REQ-020 A write SHALL update only the byte lanes whose PSTRB bit is 1; PSTRB=0000 SHALL leave the register unchanged without error.
REQ-021 A write to offset 3, or an access to any offset above 3, SHALL complete with PSLVERR=1 and no state change; a read error SHALL return 0.
REQ-022 PSLVERR and send_r_out SHALL be registered at transfer completion and held until the next completion; a write completion SHALL NOT change send_r_out.
REQ-023 Per bit of o_port: DIR=0 -> 1'bz; DIR=1 and MODE=0 -> DOUT; DIR=1 and MODE=1 -> 0 if DOUT=0, else 1'bz.
REQ-024 o_port SHALL be combinational from the registers, so a write takes effect in the cycle after completion.
REQ-025 DIN SHALL sample i_port on every PCLK edge regardless of DIR.
REQ-026 A transfer SHALL be atomic once in ACCESS; a transfer=0 during SETUP SHALL NOT abort it.

Reset
REQ-027 While PRESETn=0, the FSM SHALL be IDLE and MODE, DIR, DOUT, DIN, send_r_out and PSLVERR SHALL be 0; o_port SHALL therefore be all 1'bz.
REQ-028 Reset assertion mid-transfer SHALL abort the transfer without a register update.

Configuration
REQ-029 The macro APB_GPIO_INPUT_SYNC_EN SHALL control input synchronization: when defined, i_port passes through a two-flop synchronizer before DIN (2-cycle latency); when undefined, DIN is a single register (1-cycle latency).

Verification
REQ-030 Reset, transfer=1, write, addr 0, data 0, PSTRB=1111 -> after completion, MODE=0 and PSLVERR=0.
REQ-031 Write addr 1 with FFFFFFFF, then addr 2 with 15 (MODE=0) -> o_port=0000000F, PSLVERR=0.
REQ-032 DIR=0, i_port=10, read addr 3 after sync latency -> send_r_out=10, PSLVERR=0, o_port all Z.
REQ-033 Write addr 3 or addr 5, or addr bit 32=1 -> PSLVERR=1 and registers unchanged.
REQ-034 Write addr 2 with FFFFFFFF and PSTRB=0010 over DOUT=0 -> DOUT=0000FF00.
REQ-035 MODE=FFFFFFFF, DIR=FFFFFFFF, DOUT=0000000F -> o_port low bits Z, upper 28 bits 0.
